// File: rtl/ttc_counter_events28.sv
// Timer/counter event engine: prescaled up/down counter with interval, match and overflow
// event pulses, controlled through a small write-only register file.
module ttc_counter_events28 (
  input  logic        pclk28,
  input  logic        n_p_reset28,
  input  logic        wr_en28,
  input  logic [2:0]  reg_addr28,
  input  logic [15:0] pwdata28,
  output logic        interval_intr28,
  output logic [3:1]  match_intr28,
  output logic        overflow_intr28,
  output logic        restart28,
  output logic [15:0] count_val28,
  output logic [6:0]  ctrl_out28
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PS_W  = 8;
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_INTV   = 3'd1;
  localparam logic [2:0] ADDR_MATCH1 = 3'd2;
  localparam logic [2:0] ADDR_MATCH2 = 3'd3;
  localparam logic [2:0] ADDR_MATCH3 = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             count_en, interval_mode, decrement, match_en, prescale_en;
  logic [2:0]       prescale_exp;
  logic [CNT_W-1:0] interval, match1, match2, match3, count;
  logic [PS_W-1:0]  prescaler;

  logic             tick, restart_wr, int_hit, ovf_hit;
  logic [2:0]       match_hit;
  logic [PS_W-1:0]  ps_term, ps_next;
  logic [CNT_W-1:0] cnt_next;

  assign count_val28 = count;
  assign ctrl_out28  = {prescale_exp, prescale_en, match_en, decrement, interval_mode};

  // Tick generation, counter next value and event detection
  always_comb begin
    ps_term    = PS_W'(8'hFF >> (3'd7 - prescale_exp));
    ps_next    = prescaler;
    tick       = 1'b0;
    cnt_next   = count;
    int_hit    = 1'b0;
    ovf_hit    = 1'b0;
    match_hit  = 3'b000;
    restart_wr = wr_en28 && (reg_addr28 == ADDR_CTRL) && pwdata28[4];

    if (count_en) begin
      if (prescale_en) begin
        if (prescaler == ps_term) begin
          ps_next = '0;
          tick    = 1'b1;
        end else begin
          ps_next = prescaler + PS_W'(1);
        end
      end else begin
        tick = 1'b1;
      end
    end

    if (tick) begin
      if (!decrement) begin
        if (interval_mode && (count == interval)) begin
          cnt_next = '0;
          int_hit  = 1'b1;
        end else if (!interval_mode && (count == CNT_MAX)) begin
          cnt_next = '0;
          ovf_hit  = 1'b1;
        end else begin
          cnt_next = count + CNT_W'(1);
        end
      end else begin
        if (count == '0) begin
          cnt_next = interval_mode ? interval : CNT_MAX;
          int_hit  = interval_mode;
          ovf_hit  = !interval_mode;
        end else begin
          cnt_next = count - CNT_W'(1);
        end
      end
      match_hit = {3{match_en}} &
                  {cnt_next == match3, cnt_next == match2, cnt_next == match1};
    end

    // Restart wins over a coincident tick and uses the mode bits being written
    if (restart_wr) begin
      ps_next   = '0;
      int_hit   = 1'b0;
      ovf_hit   = 1'b0;
      match_hit = 3'b000;
      if (!pwdata28[2])     cnt_next = '0;
      else if (pwdata28[1]) cnt_next = interval;
      else                  cnt_next = CNT_MAX;
    end
  end

  always_ff @(posedge pclk28 or negedge n_p_reset28) begin
    if (!n_p_reset28) begin
      count_en        <= 1'b0;
      interval_mode   <= 1'b0;
      decrement       <= 1'b0;
      match_en        <= 1'b0;
      prescale_en     <= 1'b0;
      prescale_exp    <= 3'd0;
      interval        <= '0;
      match1          <= '0;
      match2          <= '0;
      match3          <= '0;
      count           <= '0;
      prescaler       <= '0;
      interval_intr28 <= 1'b0;
      match_intr28    <= 3'b000;
      overflow_intr28 <= 1'b0;
      restart28       <= 1'b0;
    end else begin
      count           <= cnt_next;
      prescaler       <= ps_next;
      interval_intr28 <= int_hit;
      match_intr28    <= match_hit;
      overflow_intr28 <= ovf_hit;
      restart28       <= restart_wr;
      if (wr_en28) begin
        case (reg_addr28)
          ADDR_CTRL: begin
            count_en      <= pwdata28[0];
            interval_mode <= pwdata28[1];
            decrement     <= pwdata28[2];
            match_en      <= pwdata28[3];
            prescale_en   <= pwdata28[5];
            prescale_exp  <= pwdata28[8:6];
          end
          ADDR_INTV:   interval <= pwdata28;
          ADDR_MATCH1: match1   <= pwdata28;
          ADDR_MATCH2: match2   <= pwdata28;
          ADDR_MATCH3: match3   <= pwdata28;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttc_counter_events28.sv
// Directed bench for ttc_counter_events28: vector table for the main count modes plus
// hand-written prescale, restart-collision, zero-interval and mid-run reset sequences.
module tb_ttc_counter_events28;

  logic        pclk28 = 1'b0;
  logic        n_p_reset28;
  logic        wr_en28;
  logic [2:0]  reg_addr28;
  logic [15:0] pwdata28;
  logic        interval_intr28;
  logic [3:1]  match_intr28;
  logic        overflow_intr28;
  logic        restart28;
  logic [15:0] count_val28;
  logic [6:0]  ctrl_out28;

  int n_cmp = 0;
  int n_bad = 0;

  ttc_counter_events28 dut (
    .pclk28         (pclk28),
    .n_p_reset28    (n_p_reset28),
    .wr_en28        (wr_en28),
    .reg_addr28     (reg_addr28),
    .pwdata28       (pwdata28),
    .interval_intr28(interval_intr28),
    .match_intr28   (match_intr28),
    .overflow_intr28(overflow_intr28),
    .restart28      (restart28),
    .count_val28    (count_val28),
    .ctrl_out28     (ctrl_out28)
  );

  always #5 pclk28 = ~pclk28;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] cnt;
    logic [6:0]  ctl;
    logic        intv;
    logic [2:0]  mat;
    logic        ovf;
    logic        rst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic [2:0] addr, logic [15:0] data, logic [15:0] cnt,
                              logic [6:0] ctl, logic intv, logic [2:0] mat, logic ovf, logic rst);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.cnt = cnt; v.ctl = ctl;
    v.intv = intv; v.mat = mat; v.ovf = ovf; v.rst = rst;
    return v;
  endfunction

  function automatic logic [28:0] outs();
    return {count_val28, ctrl_out28, interval_intr28, match_intr28, overflow_intr28, restart28};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle just after it
  task automatic cyc(input logic wr, input logic [2:0] addr, input logic [15:0] data);
    wr_en28    = wr;
    reg_addr28 = addr;
    pwdata28   = data;
    @(posedge pclk28);
    #1;
    wr_en28 = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 16'h0000);
  endtask

  initial begin
    n_p_reset28 = 1'b0;
    wr_en28     = 1'b0;
    reg_addr28  = 3'd0;
    pwdata28    = 16'h0000;

    // Up, interval 5: 0..5 then 0 with an interval pulse
    vecs.push_back(mk(1, 3'd1, 16'h0005, 16'h0000, 7'h00, 0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'd0, 16'h0013, 16'h0000, 7'h01, 0, 3'b000, 0, 1));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0001, 7'h01, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0002, 7'h01, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0003, 7'h01, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0004, 7'h01, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0005, 7'h01, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 7'h01, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0001, 7'h01, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0002, 7'h01, 0, 3'b000, 0, 0));
    // Disable (write-cycle tick still uses old enable), then down interval 3 with matches on 2
    vecs.push_back(mk(1, 3'd0, 16'h0000, 16'h0003, 7'h00, 0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'd1, 16'h0003, 16'h0003, 7'h00, 0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'd2, 16'h0002, 16'h0003, 7'h00, 0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'd3, 16'h0002, 16'h0003, 7'h00, 0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'd4, 16'h0007, 16'h0003, 7'h00, 0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'd0, 16'h001F, 16'h0003, 7'h07, 0, 3'b000, 0, 1));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0002, 7'h07, 0, 3'b011, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0001, 7'h07, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 7'h07, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0003, 7'h07, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0002, 7'h07, 0, 3'b011, 0, 0));
    vecs.push_back(mk(1, 3'd5, 16'hFFFF, 16'h0001, 7'h07, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 7'h07, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0003, 7'h07, 1, 3'b000, 0, 0));
    // Down free-run restart to FFFF, freeze at FFFE, then up through overflow
    vecs.push_back(mk(1, 3'd0, 16'h0015, 16'hFFFF, 7'h02, 0, 3'b000, 0, 1));
    vecs.push_back(mk(1, 3'd0, 16'h0000, 16'hFFFE, 7'h00, 0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'd0, 16'h0001, 16'hFFFE, 7'h00, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'hFFFF, 7'h00, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 7'h00, 0, 3'b000, 1, 0));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0001, 7'h00, 0, 3'b000, 0, 0));

    #12;
    chk("reset_outputs", 32'(outs()), 32'd0);
    @(posedge pclk28);
    #1;
    n_p_reset28 = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].wr, vecs[i].addr, vecs[i].data);
      chk($sformatf("vec[%0d]", i), 32'(outs()),
          32'({vecs[i].cnt, vecs[i].ctl, vecs[i].intv, vecs[i].mat, vecs[i].ovf, vecs[i].rst}));
    end

    // Prescale exp=1: one increment every 4 clocks after a restart
    cyc(1, 3'd0, 16'h0071);
    chk("ps_restart_cnt", 32'(count_val28), 32'd0);
    chk("ps_restart_pulse", 32'(restart28), 32'd1);
    chk("ps_ctrl_out", 32'(ctrl_out28), 32'h18);
    for (int k = 1; k <= 8; k++) begin
      idle();
      chk($sformatf("ps_cnt_k%0d", k), 32'(count_val28), 32'(k / 4));
    end
    idle();
    idle();
    cyc(1, 3'd0, 16'h0060);
    for (int k = 0; k < 10; k++) idle();
    chk("ps_frozen_cnt", 32'(count_val28), 32'd2);
    cyc(1, 3'd0, 16'h0061);
    chk("ps_reenable_cnt", 32'(count_val28), 32'd2);
    idle();
    chk("ps_held_prescaler_tick", 32'(count_val28), 32'd3);

    // Restart coinciding with the interval terminal count
    cyc(1, 3'd0, 16'h0000);
    cyc(1, 3'd1, 16'h0002);
    cyc(1, 3'd0, 16'h0013);
    idle();
    idle();
    chk("coll_pre_cnt", 32'(count_val28), 32'd2);
    cyc(1, 3'd0, 16'h0013);
    chk("coll_cnt", 32'(count_val28), 32'd0);
    chk("coll_restart", 32'(restart28), 32'd1);
    chk("coll_no_intv", 32'(interval_intr28), 32'd0);
    idle();
    chk("coll_after", 32'({count_val28, interval_intr28, restart28}), 32'({16'd1, 1'b0, 1'b0}));

    // Interval 0 in up interval mode: stays at 0, interval pulse every tick
    cyc(1, 3'd1, 16'h0000);
    chk("iv0_write_tick_old", 32'(count_val28), 32'd2);
    cyc(1, 3'd0, 16'h0013);
    chk("iv0_restart", 32'({count_val28, interval_intr28, restart28}), 32'({16'd0, 1'b0, 1'b1}));
    for (int k = 0; k < 3; k++) begin
      idle();
      chk($sformatf("iv0_tick%0d", k), 32'({count_val28, interval_intr28}), 32'({16'd0, 1'b1}));
    end

    // Mid-run reset: outputs drop at once and nothing restarts without a new control write
    cyc(1, 3'd0, 16'h0001);
    idle();
    idle();
    idle();
    chk("pre_reset_cnt", 32'(count_val28), 32'd3);
    #2;
    n_p_reset28 = 1'b0;
    #1;
    chk("midrun_reset_outputs", 32'(outs()), 32'd0);
    @(posedge pclk28);
    @(posedge pclk28);
    #1;
    n_p_reset28 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle();
      chk($sformatf("post_reset_idle%0d", k), 32'(outs()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
